// File: rtl/quad_pkg.sv
// Shared constants and helpers for the quadrature step decoder.
// Gray-code states, direction encodings and the forward-sequence lookup.
package quad_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  typedef struct packed {
    logic step;
    logic dir;
    logic err;
  } quad_evt_t;

  function automatic logic [1:0] quad_next(
    input logic [1:0] prev
  );
    logic [1:0] nx;
    nx = S00;
    unique case (prev)
      S00:     nx = S01;
      S01:     nx = S11;
      S11:     nx = S10;
      S10:     nx = S00;
      default: nx = S00;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Per-channel input synchroniser followed by a stability filter.
// The output only follows the input after FILT_LEN steady cycles.
module quad_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clck,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW =
    (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_prev;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nx;
  logic                   hit;

  assign s = sync[SYNC_STAGES-1];

  // A fresh difference (toggle) restarts the run at zero.
  always_comb begin
    cnt_nx = '0;
    if (s != dout && s == s_prev)
      cnt_nx = cnt + 1'b1;
  end

  assign hit = (s != dout) &&
               (cnt_nx == CW'(FILT_LEN - 1));

  always_ff @(posedge clck) begin
    if (rst) begin
      sync   <= '0;
      s_prev <= 1'b0;
      cnt    <= '0;
      dout   <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], din};
      s_prev <= s;
      if (hit) begin
        dout <= s;
        cnt  <= '0;
      end else begin
        cnt  <= cnt_nx;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: filtered A/B to step/dir pulses.
// Also flags and counts illegal two-bit jumps.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clck,
  input  logic                 rst,
  input  logic                 en_dec,
  input  logic                 qa,
  input  logic                 qb,
  output logic                 step,
  output logic                 dir,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           state
);

  // Extra cycle covers the decode compare after the filter settles.
  localparam int WARM = SYNC_STAGES + FILT_LEN + 1;
  localparam int WW   = $clog2(WARM + 1);

  logic          fa;
  logic          fb;
  logic [1:0]    cur;
  logic [1:0]    prev;
  logic [1:0]    delta;
  logic [WW-1:0] wcnt;
  logic          live;
  quad_evt_t     evt;

  quad_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_a (
    .clck(clck),
    .rst (rst),
    .din (qa),
    .dout(fa)
  );

  quad_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_b (
    .clck(clck),
    .rst (rst),
    .din (qb),
    .dout(fb)
  );

  assign cur   = {fa, fb};
  assign state = cur;
  assign delta = cur ^ prev;
  assign live  = (wcnt == WW'(WARM));

  always_comb begin
    evt.step = 1'b0;
    evt.dir  = dir;
    evt.err  = 1'b0;
    if (live && en_dec) begin
      unique case (1'b1)
        (delta == 2'b11): begin
          evt.err = 1'b1;
        end
        (delta == 2'b00): begin
          evt.step = 1'b0;
        end
        (cur == quad_next(prev)): begin
          evt.step = 1'b1;
          evt.dir  = DIR_UP;
        end
        default: begin
          evt.step = 1'b1;
          evt.dir  = DIR_DN;
        end
      endcase
    end
  end

  always_ff @(posedge clck) begin
    if (rst) begin
      wcnt    <= '0;
      prev    <= S00;
      step    <= 1'b0;
      dir     <= DIR_DN;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (!live)
        wcnt <= wcnt + 1'b1;
      prev <= cur;
      step <= evt.step;
      dir  <= evt.dir;
      err  <= evt.err;
      if (evt.err && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder.
// Expected events queued at drive time, matched to observed pulses.
module tb_quad_step_decoder;
  import quad_pkg::*;

  localparam int SS = 2;
  localparam int FL = 4;
  localparam int EW = 8;

  logic          clck = 1'b0;
  logic          rst;
  logic          en_dec;
  logic          qa;
  logic          qb;
  logic          step;
  logic          dir;
  logic          err;
  logic [EW-1:0] err_cnt;
  logic [1:0]    state;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         evt_cyc = 0;
  int         t0;
  logic [7:0] dcnt = 8'd0;
  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];

  always #5 clck = ~clck;

  quad_step_decoder #(
    .SYNC_STAGES(SS),
    .FILT_LEN   (FL),
    .ERR_CNT_W  (EW)
  ) dut (
    .clck   (clck),
    .rst    (rst),
    .en_dec (en_dec),
    .qa     (qa),
    .qb     (qb),
    .step   (step),
    .dir    (dir),
    .err    (err),
    .err_cnt(err_cnt),
    .state  (state)
  );

  always @(posedge clck) cyc <= cyc + 1;

  // Event log plus a model of the downstream up/down counter.
  always @(negedge clck) begin
    if (step || err) begin
      obs_q.push_back({err, dir, step});
      evt_cyc = cyc;
    end
    if (step)
      dcnt = dir ? dcnt + 8'd1 : dcnt - 8'd1;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic go(input logic [1:0] ab, input int n);
    qa = ab[1];
    qb = ab[0];
    repeat (n) @(posedge clck);
    #1;
  endtask

  task automatic mv(input logic [1:0] ab, input logic d);
    exp_q.push_back({1'b0, d, 1'b1});
    go(ab, 10);
  endtask

  task automatic drain(input string tag);
    logic [2:0] e;
    logic [2:0] o;
    int         b;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      b = 0;
      while (obs_q.size() == 0 && b < 40) begin
        @(posedge clck);
        #1;
        b++;
      end
      if (obs_q.size() == 0) begin
        chk({tag, "_timeout"}, obs_q.size(), 1);
      end else begin
        o = obs_q.pop_front();
        chk(tag, o, e);
      end
    end
    repeat (12) @(posedge clck);
    #1;
    chk({tag, "_extra"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (3) @(posedge clck);
    #1;
    chk({tag, "_step"}, step, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_dir"}, dir, 0);
    chk({tag, "_cnt"}, err_cnt, 0);
    chk({tag, "_state"}, state, 0);
    rst = 1'b0;
    obs_q.delete();
  endtask

  initial begin
    rst    = 1'b1;
    en_dec = 1'b1;
    qa     = 1'b0;
    qb     = 1'b0;
    @(posedge clck);
    #1;
    do_reset("rst0");
    go(S00, 14);

    // 8 forward steps, first one timed
    dcnt = 8'd0;
    t0   = cyc;
    mv(S01, DIR_UP);
    chk("latency", evt_cyc - t0, SS + FL + 1);
    mv(S11, DIR_UP);
    mv(S10, DIR_UP);
    mv(S00, DIR_UP);
    mv(S01, DIR_UP);
    mv(S11, DIR_UP);
    mv(S10, DIR_UP);
    mv(S00, DIR_UP);
    drain("fwd8");
    chk("fwd8_dcnt", dcnt, 8);
    chk("fwd8_errcnt", err_cnt, 0);
    chk("fwd8_dir", dir, 1);

    // 3 forward then 5 reverse
    dcnt = 8'd0;
    mv(S01, DIR_UP);
    mv(S11, DIR_UP);
    mv(S10, DIR_UP);
    mv(S11, DIR_DN);
    mv(S01, DIR_DN);
    mv(S00, DIR_DN);
    mv(S10, DIR_DN);
    mv(S11, DIR_DN);
    drain("fwdrev");
    chk("fwdrev_dcnt", dcnt, 8'hFE);
    chk("fwdrev_dir", dir, 0);

    // glitches on qa, from state 11
    go(S01, FL - 1);
    go(S11, 14);
    drain("glitch_short");
    chk("glitch_state", state, S11);
    exp_q.push_back({1'b0, DIR_DN, 1'b1});
    exp_q.push_back({1'b0, DIR_UP, 1'b1});
    go(S01, FL);
    go(S11, 14);
    drain("glitch_long");

    // illegal jump and saturation
    mv(S10, DIR_UP);
    mv(S00, DIR_UP);
    drain("pre_jump");
    exp_q.push_back({1'b1, DIR_UP, 1'b0});
    go(S11, 10);
    drain("jump");
    chk("jump_errcnt", err_cnt, 1);
    chk("jump_state", state, S11);
    for (int i = 0; i < 258; i++)
      go((i % 2 == 0) ? S00 : S11, 10);
    repeat (12) @(posedge clck);
    #1;
    chk("flood_errs", obs_q.size(), 258);
    obs_q.delete();
    chk("sat_errcnt", err_cnt, 255);

    // pins at 11 through reset
    do_reset("rst11");
    go(S11, 20);
    drain("warm11");
    chk("warm11_state", state, S11);

    // decode disabled while moving
    en_dec = 1'b0;
    go(S10, 10);
    go(S00, 10);
    go(S01, 10);
    go(S11, 10);
    en_dec = 1'b1;
    go(S11, 10);
    drain("disabled");
    mv(S10, DIR_UP);
    drain("reenable");

    // reset in the middle of a transition
    go(S00, 3);
    rst = 1'b1;
    @(posedge clck);
    #1;
    chk("midrst_step", step, 0);
    chk("midrst_err", err, 0);
    chk("midrst_dir", dir, 0);
    chk("midrst_cnt", err_cnt, 0);
    chk("midrst_state", state, 0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
